// File: rtl/recorder.sv
// -----------------------------------------------------------------------------
// recorder
//
// Capture side of the replay path. While recording, din is sampled once every
// DIV enabled clock cycles and written to the shared sample RAM at consecutive
// addresses 0,1,2,... The number of samples captured is reported on length,
// which the replayer uses as its read limit.
//
// Ports
//   clk      in   1  system clock, rising edge
//   rst_n    in   1  asynchronous active-low reset
//   enable   in   1  tick gate; while low the tick counter and recording freeze
//   start    in   1  one-cycle pulse: clear and (re)start recording
//   stop     in   1  one-cycle pulse: end recording early (RECORD only)
//   max_len  in   8  capacity in samples, captured on start
//   din      in   8  sample data
//   write    out  1  RAM write strobe, one cycle per sample
//   addr     out  8  RAM write address
//   wdata    out  8  RAM write data
//   length   out  8  samples written in the current/last recording
//   ready    out  1  high in IDLE/DONE
//   done     out  1  high in DONE
// -----------------------------------------------------------------------------
module recorder #(
  parameter int CLOCK_FREQ_HZ = 12000000,
  parameter int TICK_PER_SEC  = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       start,
  input  logic       stop,
  input  logic [7:0] max_len,
  input  logic [7:0] din,
  output logic       write,
  output logic [7:0] addr,
  output logic [7:0] wdata,
  output logic [7:0] length,
  output logic       ready,
  output logic       done
);

  localparam int QUOT  = CLOCK_FREQ_HZ / TICK_PER_SEC;
  // A clock slower than the tick rate degenerates to one sample per cycle.
  localparam int DIV   = (QUOT == 0) ? 1 : QUOT;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       cap;
  logic             tick;

  assign tick = (state == RECORD) && enable && (cnt == CNT_LAST);

  // State register
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. start takes priority over everything, including a
  // coincident tick or stop.
  // NOTE: next_state gets a default before any branch so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    if (start) begin
      next_state = (max_len == 8'd0) ? DONE : RECORD;
    end else if (state == RECORD) begin
      // A tick together with stop still writes; the sample is counted first.
      if ((tick && (length + 8'd1 == cap)) || stop) begin
        next_state = DONE;
      end
    end
  end

  // Datapath and registered status decodes. done/ready are decoded from
  // next_state so they switch on the same edge as state itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      cap    <= 8'd0;
      write  <= 1'b0;
      addr   <= 8'd0;
      wdata  <= 8'd0;
      length <= 8'd0;
      done   <= 1'b0;
      ready  <= 1'b1;
    end else begin
      write <= 1'b0;
      done  <= (next_state == DONE);
      ready <= (next_state != RECORD);
      if (start) begin
        cnt    <= '0;
        cap    <= max_len;
        length <= 8'd0;
      end else if ((state == RECORD) && enable) begin
        if (tick) begin
          cnt    <= '0;
          write  <= 1'b1;
          addr   <= length;
          wdata  <= din;
          // cap never exceeds 255, so length cannot wrap.
          length <= length + 8'd1;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_recorder.sv
// -----------------------------------------------------------------------------
// tb_recorder
//
// Drives two recorder instances from one set of inputs: u1 with DIV=1 and u4
// with DIV=4. A behavioural model (enabled-cycle counting and sample counts)
// predicts both every cycle; a constant vector table and directed sequences
// cover the corner cases, then randomized traffic runs against the model.
// -----------------------------------------------------------------------------
module tb_recorder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       enable = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] max_len = 8'd0;
  logic [7:0] din = 8'd0;

  logic       w1, w4, r1, r4, dn1, dn4;
  logic [7:0] a1, a4, d1, d4, l1, l4;

  recorder #(.CLOCK_FREQ_HZ(1), .TICK_PER_SEC(3)) u1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .start(start), .stop(stop),
    .max_len(max_len), .din(din), .write(w1), .addr(a1), .wdata(d1),
    .length(l1), .ready(r1), .done(dn1)
  );

  recorder #(.CLOCK_FREQ_HZ(4), .TICK_PER_SEC(1)) u4 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .start(start), .stop(stop),
    .max_len(max_len), .din(din), .write(w4), .addr(a4), .wdata(d4),
    .length(l4), .ready(r4), .done(dn4)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int div_of [2] = '{1, 4};
  bit m_rec  [2];
  bit m_fin  [2];
  bit m_wr   [2];
  int m_en   [2];   // enabled RECORD cycles since start
  int m_n    [2];   // samples written since start
  int m_cap  [2];
  int m_addr [2];
  int m_wdata[2];
  int wcnt   [2];   // total observed writes per instance

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_rec[i] = 0; m_fin[i] = 0; m_wr[i] = 0; m_en[i] = 0;
      m_n[i] = 0; m_cap[i] = 0; m_addr[i] = 0; m_wdata[i] = 0;
    end
  endtask

  task automatic model_edge(input int i);
    m_wr[i] = 0;
    if (start) begin
      m_n[i]   = 0;
      m_en[i]  = 0;
      m_cap[i] = int'(max_len);
      m_rec[i] = (max_len != 8'd0);
      m_fin[i] = (max_len == 8'd0);
    end else if (m_rec[i]) begin
      if (enable) begin
        m_en[i]++;
        if (m_en[i] % div_of[i] == 0) begin
          m_wr[i]    = 1;
          m_addr[i]  = m_n[i];
          m_wdata[i] = int'(din);
          m_n[i]++;
          if (m_n[i] == m_cap[i]) begin
            m_rec[i] = 0;
            m_fin[i] = 1;
          end
        end
      end
      if (stop && m_rec[i]) begin
        m_rec[i] = 0;
        m_fin[i] = 1;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, " u1.write"},  32'(w1),  32'(m_wr[0]));
    check({tag, " u1.addr"},   32'(a1),  32'(m_addr[0]));
    check({tag, " u1.wdata"},  32'(d1),  32'(m_wdata[0]));
    check({tag, " u1.length"}, 32'(l1),  32'(m_n[0]));
    check({tag, " u1.done"},   32'(dn1), 32'(m_fin[0]));
    check({tag, " u1.ready"},  32'(r1),  32'(!m_rec[0]));
    check({tag, " u4.write"},  32'(w4),  32'(m_wr[1]));
    check({tag, " u4.addr"},   32'(a4),  32'(m_addr[1]));
    check({tag, " u4.wdata"},  32'(d4),  32'(m_wdata[1]));
    check({tag, " u4.length"}, 32'(l4),  32'(m_n[1]));
    check({tag, " u4.done"},   32'(dn4), 32'(m_fin[1]));
    check({tag, " u4.ready"},  32'(r4),  32'(!m_rec[1]));
  endtask

  // One clock: model sees the pre-edge inputs, outputs compared 1 time unit
  // later; the caller changes inputs after return, well away from the edge.
  task automatic step(input string tag);
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    compare_all(tag);
    wcnt[0] += int'(w1);
    wcnt[1] += int'(w4);
  endtask

  task automatic set_in(input logic st, input logic sp, input logic en,
                        input logic [7:0] ml, input logic [7:0] di);
    start = st; stop = sp; enable = en; max_len = ml; din = di;
  endtask

  task automatic pulse_start(input logic [7:0] ml, input string tag);
    set_in(1'b1, 1'b0, 1'b0, ml, 8'd0);
    step(tag);
    start = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all({tag, " async"});
    @(posedge clk);
    #1;
    compare_all({tag, " held"});
    rst_n = 1'b1;
  endtask

  // ---------------- constant vector table (u1, DIV=1) ----------------
  typedef struct {
    logic       st, sp, en;
    logic [7:0] ml, di;
    logic       ew;
    logic [7:0] ea, ed, el;
    logic       edn, erd;
  } vec_t;

  vec_t vt[13];

  initial begin
    int base, nw, gap, k;
    int wk[$];

    //          st sp en ml  di     ew ea ed   el edn erd
    vt[0]  = '{1, 0, 0, 3,  0,     0, 0, 0,   0, 0, 0};
    vt[1]  = '{0, 0, 1, 0,  11,    1, 0, 11,  1, 0, 0};
    vt[2]  = '{0, 0, 1, 0,  22,    1, 1, 22,  2, 0, 0};
    vt[3]  = '{0, 0, 0, 0,  33,    0, 1, 22,  2, 0, 0};
    vt[4]  = '{0, 1, 1, 0,  44,    1, 2, 44,  3, 1, 1};
    vt[5]  = '{0, 0, 1, 0,  55,    0, 2, 44,  3, 1, 1};
    vt[6]  = '{1, 1, 1, 2,  66,    0, 2, 44,  0, 0, 0};
    vt[7]  = '{0, 1, 1, 0,  77,    1, 0, 77,  1, 1, 1};
    vt[8]  = '{0, 1, 1, 0,  88,    0, 0, 77,  1, 1, 1};
    vt[9]  = '{1, 0, 1, 5,  99,    0, 0, 77,  0, 0, 0};
    vt[10] = '{0, 0, 1, 0,  100,   1, 0, 100, 1, 0, 0};
    vt[11] = '{1, 0, 1, 5,  101,   0, 0, 100, 0, 0, 0};
    vt[12] = '{0, 1, 0, 0,  0,     0, 0, 100, 0, 1, 1};

    wcnt[0] = 0; wcnt[1] = 0;

    // Reset must take effect without any clock edge (first posedge at t=5).
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("reset write",  32'(w1),  32'd0);
    check("reset addr",   32'(a1),  32'd0);
    check("reset length", 32'(l1),  32'd0);
    check("reset done",   32'(dn1), 32'd0);
    check("reset ready",  32'(r1),  32'd1);
    compare_all("reset");
    #1;
    rst_n = 1'b1;

    // Table vectors
    for (int i = 0; i < 13; i++) begin
      set_in(vt[i].st, vt[i].sp, vt[i].en, vt[i].ml, vt[i].di);
      step($sformatf("vec%0d", i));
      check($sformatf("vec%0d write", i),  32'(w1),  32'(vt[i].ew));
      check($sformatf("vec%0d addr", i),   32'(a1),  32'(vt[i].ea));
      check($sformatf("vec%0d wdata", i),  32'(d1),  32'(vt[i].ed));
      check($sformatf("vec%0d length", i), 32'(l1),  32'(vt[i].el));
      check($sformatf("vec%0d done", i),   32'(dn1), 32'(vt[i].edn));
      check($sformatf("vec%0d ready", i),  32'(r1),  32'(vt[i].erd));
    end
    set_in(0, 0, 0, 0, 0);
    step("idle");

    // 13 consecutive writes with DIV=1
    pulse_start(8'd13, "capA start");
    base = wcnt[0];
    for (int n = 0; n < 16; n++) begin
      set_in(0, 0, 1, 0, 8'hA0 + 8'(n));
      step("capA");
    end
    check("capA writes", 32'(wcnt[0] - base), 32'd13);
    check("capA length", 32'(l1), 32'd13);
    check("capA done",   32'(dn1), 32'd1);
    check("capA ready",  32'(r1),  32'd1);

    // Same, with enable low for 3 cycles after the 5th write
    pulse_start(8'd13, "capB start");
    base = wcnt[0];
    gap = 0;
    for (int n = 0; n < 20; n++) begin
      nw = wcnt[0] - base;
      if (nw == 5 && gap < 3) begin
        set_in(0, 0, 0, 0, 8'hA0 + 8'(n));
        gap++;
        step("capB gap");
        check("capB gap write", 32'(w1), 32'd0);
      end else begin
        set_in(0, 0, 1, 0, 8'hA0 + 8'(n));
        step("capB");
        if (nw == 5 && w1) check("capB resume addr", 32'(a1), 32'd5);
      end
    end
    check("capB writes", 32'(wcnt[0] - base), 32'd13);
    check("capB length", 32'(l1), 32'd13);

    // stop coinciding with the 6th write
    pulse_start(8'd20, "stop start");
    base = wcnt[0];
    for (int n = 1; n <= 10; n++) begin
      set_in(0, n == 6, 1, 0, 8'(n * 7));
      step("stop");
      if (n == 6) check("stop 6th addr", 32'(a1), 32'd5);
    end
    check("stop writes", 32'(wcnt[0] - base), 32'd6);
    check("stop length", 32'(l1), 32'd6);
    check("stop done",   32'(dn1), 32'd1);

    // max_len=0 goes straight to DONE, then restart from DONE with max_len=3
    pulse_start(8'd0, "zero start");
    check("zero done",   32'(dn1), 32'd1);
    check("zero length", 32'(l1),  32'd0);
    base = wcnt[0];
    for (int n = 0; n < 4; n++) begin
      set_in(0, 0, 1, 0, 8'(n));
      step("zero idle");
    end
    check("zero writes", 32'(wcnt[0] - base), 32'd0);
    pulse_start(8'd3, "rest start");
    base = wcnt[0];
    for (int n = 0; n < 6; n++) begin
      set_in(0, 0, 1, 0, 8'h50 + 8'(n));
      step("rest");
      if (n == 0) check("rest first addr", 32'(a1), 32'd0);
    end
    check("rest writes", 32'(wcnt[0] - base), 32'd3);
    check("rest length", 32'(l1), 32'd3);

    // DIV=4: writes every 4 enabled cycles
    pulse_start(8'd3, "div4 start");
    for (int n = 1; n <= 16; n++) begin
      set_in(0, 0, 1, 0, 8'(n));
      step("div4");
      if (w4) wk.push_back(n);
    end
    check("div4 count", 32'(wk.size()), 32'd3);
    if (wk.size() == 3) begin
      check("div4 first", 32'(wk[0]), 32'd4);
      check("div4 gap1",  32'(wk[1] - wk[0]), 32'd4);
      check("div4 gap2",  32'(wk[2] - wk[1]), 32'd4);
    end
    check("div4 length", 32'(l4), 32'd3);
    check("div4 done",   32'(dn4), 32'd1);

    // DIV=4 with reset mid-recording
    pulse_start(8'd3, "rst start");
    for (int n = 0; n < 6; n++) begin
      set_in(0, 0, 1, 0, 8'hC0 + 8'(n));
      step("rst pre");
    end
    do_reset("midrst");
    check("midrst u4 write",  32'(w4),  32'd0);
    check("midrst u4 addr",   32'(a4),  32'd0);
    check("midrst u4 length", 32'(l4),  32'd0);
    check("midrst u4 ready",  32'(r4),  32'd1);
    base = wcnt[1];
    for (int n = 0; n < 10; n++) begin
      set_in(0, 0, 1, 0, 8'(n));
      step("rst post");
    end
    check("midrst no writes", 32'(wcnt[1] - base), 32'd0);
    check("midrst idle ready", 32'(r4), 32'd1);

    // Randomized traffic against the model
    for (k = 0; k < 3000; k++) begin
      set_in(($urandom % 40) == 0,
             ($urandom % 25) == 0,
             ($urandom % 4) != 0,
             (($urandom % 8) == 0) ? 8'($urandom % 256) : 8'($urandom % 12),
             8'($urandom));
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
